mem_scrub_arbiter: RTL and testbench
====================================

Name: mem_scrub_arbiter

Overview:
Background SECDED scrubber and port arbiter for the encoded data memory. It shares the single memory port between the voted core path and an internal scrub engine. The scrub engine walks every word, checks it through the external SECDED decoder, and writes back corrected codewords for single-bit errors. It sits between the voter/recovery write-enable path and the data memory, beside the read-side decoder and a re-encoder.

Parameters:
DEPTH, 64, number of 39-bit words scrubbed (word index 0..DEPTH-1)
IDX_W, 6, width of scrub word index, equal to clog2(DEPTH)
SCRUB_INTERVAL, 256, idle cycles between consecutive word scrubs
CNT_W, 16, width of the error counters

Ports:
clk  in  1  clock; all state changes on rising edge
rst_in  in  1  asynchronous reset, active-low
scrub_en  in  1  enables scrubbing
core_req  in  1  core is using memory this cycle (load or store)
core_we  in  1  core write enable (from write-enable demux, data side)
core_addr  in  32  core byte address (ALUResult)
core_wdata  in  39  core encoded write data
mem_we  out  1  memory write enable
mem_addr  out  32  memory byte address
mem_wdata  out  39  memory write data
dec_sb_err  in  1  decoder flag: single-bit error in mem_rdata at mem_addr
dec_db_err  in  1  decoder flag: double-bit error in mem_rdata at mem_addr
corr_codeword  in  39  re-encoded corrected word for current mem_rdata
scrub_grant  out  1  scrubber owns the port this cycle
busy  out  1  FSM not in IDLE
sb_count  out  CNT_W  single-bit errors found, saturating
db_count  out  CNT_W  double-bit errors found, saturating
db_err  out  1  one-cycle pulse on double-bit detection
db_addr  out  32  byte address of the last double-bit error
pass_done  out  1  one-cycle pulse after word DEPTH-1 is processed

Behaviour:
- Reset (rst_in=0, async):
  - state=IDLE, interval counter=SCRUB_INTERVAL-1, idx=0, latched codeword=0.
  - sb_count=0, db_count=0, db_addr=0, db_err=0, pass_done=0, scrub_grant=0, busy=0.
  - Reset mid-operation abandons any pending writeback; no memory write is issued.
- Port mux (combinational):
  - When scrub_grant=0: mem_we/mem_addr/mem_wdata = core_we/core_addr/core_wdata.
  - When scrub_grant=1: mem_addr={idx,2'b00} zero-extended to 32 bits; mem_wdata=latched codeword; mem_we=1 only in WB.
  - scrub_grant=1 only in READ or WB, and only while core_req=0. The core always has priority and is never stalled.
- FSM states:
  - IDLE:
    - While scrub_en=1, the counter decrements by 1 per cycle.
    - When the counter is 0 and scrub_en=1, go to READ and reload the counter.
    - While scrub_en=0, the counter holds.
  - READ:
    - If core_req=1, stay in READ (retry the same idx).
    - Else sample the decoder flags at the edge:
      - dec_db_err=1 takes precedence: db_count++ (saturating), db_addr={idx,2'b00}, db_err pulses the next cycle, go to NEXT. No writeback.
      - Else dec_sb_err=1: latch corr_codeword, sb_count++ (saturating), go to WB.
      - Else go to NEXT.
  - WB:
    - If core_req=1, wait in WB.
    - While waiting, if core_we=1 and core_addr[IDX_W+1:2]==idx, drop the writeback (fresh core data wins) and go to NEXT.
    - With core_req=0, drive one write cycle, then go to NEXT.
  - NEXT (one cycle):
    - idx wraps from DEPTH-1 to 0; pass_done pulses on the wrap cycle.
    - Otherwise idx = idx+1.
    - Go to IDLE.
- scrub_en deasserted outside IDLE: the current word completes (READ/WB/NEXT), then the FSM parks in IDLE.
- Counters saturate at all-ones; they never wrap.
- Latency: an uncontended word takes SCRUB_INTERVAL cycles of IDLE plus 1 READ plus, if corrected, 1 WB, plus 1 NEXT.

Test Plan:
- Reset, then scrub_en=1, core_req=0, DEPTH=4, SCRUB_INTERVAL=4, clean memory -> idx visits 0,1,2,3; pass_done pulses once after word 3; sb_count=0; mem_we never asserted.
- Inject a 1-bit flip in word 2 -> in READ of idx 2, sb_count becomes 1; next cycle mem_we=1, mem_addr=0x8, mem_wdata=corrected codeword; a second pass sees no error.
- Inject a 2-bit flip in word 1 -> db_count=1, db_err is a single-cycle pulse, db_addr=0x4, no write; the error is detected again on the next pass (db_count=2).
- Hold core_req=1 throughout READ for 10 cycles -> scrub_grant=0, mem_addr follows core_addr; the scrub of the same idx completes on the first cycle core_req=0.
- Word 3 single-bit error with core_req=1, core_we=1, core_addr=0xC during WB -> writeback dropped; memory holds core_wdata; FSM goes NEXT then IDLE.
- Assert rst_in=0 while in WB -> all outputs take reset values immediately, no write occurs, and after release scrubbing restarts at idx 0.

Source files
------------

// File: rtl/mem_scrub_arbiter.sv
// mem_scrub_arbiter
// Background SECDED scrubber sharing the single data-memory port with the core.
// The core always wins the port; the scrub engine only drives the port in
// READ/WB cycles where core_req is low. Each word is read through the external
// decoder. Single-bit errors are written back with the re-encoded codeword.
// Double-bit errors are only counted and reported.
//
// Ports:
//   clk, rst_in           clock, asynchronous active-low reset
//   scrub_en              enables the scrub walk
//   core_req/we/addr/wdata  core memory request (pass-through when not granted)
//   mem_we/addr/wdata     muxed memory port
//   dec_sb_err/dec_db_err decoder flags for the word at mem_addr
//   corr_codeword         re-encoded corrected word for the current read data
//   scrub_grant           scrubber owns the port this cycle
//   busy                  scrub FSM is not idle
//   sb_count/db_count     saturating error counters
//   db_err, db_addr       double-bit pulse and address of the last one
//   pass_done             pulse after the last word of a pass is processed
module mem_scrub_arbiter #(
  parameter int DEPTH          = 64,
  parameter int IDX_W          = 6,
  parameter int SCRUB_INTERVAL = 256,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             scrub_en,
  input  logic             core_req,
  input  logic             core_we,
  input  logic [31:0]      core_addr,
  input  logic [38:0]      core_wdata,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [38:0]      mem_wdata,
  input  logic             dec_sb_err,
  input  logic             dec_db_err,
  input  logic [38:0]      corr_codeword,
  output logic             scrub_grant,
  output logic             busy,
  output logic [CNT_W-1:0] sb_count,
  output logic [CNT_W-1:0] db_count,
  output logic             db_err,
  output logic [31:0]      db_addr,
  output logic             pass_done
);

  localparam int INT_W = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam logic [INT_W-1:0] INT_RELOAD = INT_W'(SCRUB_INTERVAL - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DEPTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;
  localparam logic [1:0] ST_NEXT = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [INT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [38:0]      cw_q, cw_d;
  logic [CNT_W-1:0] sb_count_q, sb_count_d;
  logic [CNT_W-1:0] db_count_q, db_count_d;
  logic [31:0]      db_addr_q, db_addr_d;
  logic             db_err_q, db_err_d;
  logic             pass_done_q, pass_done_d;

  logic [31:0]      scrub_addr;
  logic             in_scrub;

  assign scrub_addr = {{(32 - IDX_W - 2){1'b0}}, idx_q, 2'b00};
  assign in_scrub   = (state_q == ST_READ) || (state_q == ST_WB);

  // Port mux: the scrubber only takes the port when the core is not using it.
  assign scrub_grant = in_scrub && !core_req;
  assign busy        = (state_q != ST_IDLE);
  assign mem_we      = scrub_grant ? (state_q == ST_WB) : core_we;
  assign mem_addr    = scrub_grant ? scrub_addr : core_addr;
  assign mem_wdata   = scrub_grant ? cw_q : core_wdata;

  assign sb_count  = sb_count_q;
  assign db_count  = db_count_q;
  assign db_err    = db_err_q;
  assign db_addr   = db_addr_q;
  assign pass_done = pass_done_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    cw_d        = cw_q;
    sb_count_d  = sb_count_q;
    db_count_d  = db_count_q;
    db_addr_d   = db_addr_q;
    db_err_d    = 1'b0;
    pass_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (scrub_en) begin
          if (cnt_q == '0) begin
            state_d = ST_READ;
            cnt_d   = INT_RELOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      ST_READ: begin
        // Decoder flags are only meaningful when our address is on the port.
        if (!core_req) begin
          if (dec_db_err) begin
            if (!(&db_count_q)) db_count_d = db_count_q + 1'b1;
            db_addr_d = scrub_addr;
            db_err_d  = 1'b1;
            state_d   = ST_NEXT;
          end else if (dec_sb_err) begin
            cw_d = corr_codeword;
            if (!(&sb_count_q)) sb_count_d = sb_count_q + 1'b1;
            state_d = ST_WB;
          end else begin
            state_d = ST_NEXT;
          end
        end
      end

      ST_WB: begin
        if (core_req) begin
          // A core store to the same word supersedes our stale correction.
          if (core_we && (core_addr[IDX_W+1:2] == idx_q)) state_d = ST_NEXT;
        end else begin
          state_d = ST_NEXT;
        end
      end

      ST_NEXT: begin
        if (idx_q == IDX_LAST) begin
          idx_d       = '0;
          pass_done_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= ST_IDLE;
      cnt_q       <= INT_RELOAD;
      idx_q       <= '0;
      cw_q        <= '0;
      sb_count_q  <= '0;
      db_count_q  <= '0;
      db_addr_q   <= '0;
      db_err_q    <= 1'b0;
      pass_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      cw_q        <= cw_d;
      sb_count_q  <= sb_count_d;
      db_count_q  <= db_count_d;
      db_addr_q   <= db_addr_d;
      db_err_q    <= db_err_d;
      pass_done_q <= pass_done_d;
    end
  end

endmodule

// File: tb/tb_mem_scrub_arbiter.sv
// Directed testbench for mem_scrub_arbiter with DEPTH=4, SCRUB_INTERVAL=4.
// A four-word memory and a distance-based decoder model sit on the muxed port:
// a word differing from its reference codeword in one bit flags a single-bit
// error, two or more bits flag a double-bit error.
module tb_mem_scrub_arbiter;

  logic        clk;
  logic        rst_in;
  logic        scrub_en;
  logic        core_req;
  logic        core_we;
  logic [31:0] core_addr;
  logic [38:0] core_wdata;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [38:0] mem_wdata;
  logic        dec_sb_err;
  logic        dec_db_err;
  logic [38:0] corr_codeword;
  logic        scrub_grant;
  logic        busy;
  logic [15:0] sb_count;
  logic [15:0] db_count;
  logic        db_err;
  logic [31:0] db_addr;
  logic        pass_done;

  int total = 0;
  int bad   = 0;
  int we_cnt   = 0;
  int pass_cnt = 0;

  logic [38:0] mem_arr  [4];
  logic [38:0] gold_arr [4];
  logic [38:0] diff;

  mem_scrub_arbiter #(
    .DEPTH(4), .IDX_W(2), .SCRUB_INTERVAL(4), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_in(rst_in), .scrub_en(scrub_en),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .dec_sb_err(dec_sb_err), .dec_db_err(dec_db_err),
    .corr_codeword(corr_codeword), .scrub_grant(scrub_grant), .busy(busy),
    .sb_count(sb_count), .db_count(db_count), .db_err(db_err),
    .db_addr(db_addr), .pass_done(pass_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    diff          = mem_arr[mem_addr[3:2]] ^ gold_arr[mem_addr[3:2]];
    dec_sb_err    = ($countones(diff) == 1);
    dec_db_err    = ($countones(diff) >= 2);
    corr_codeword = gold_arr[mem_addr[3:2]];
  end

  // One clock cycle: memory writes and event counting at the rising edge,
  // then return at the falling edge where inputs are driven and outputs read.
  task automatic step();
    @(posedge clk);
    if (mem_we) begin
      mem_arr[mem_addr[3:2]]  = mem_wdata;
      gold_arr[mem_addr[3:2]] = mem_wdata;
      we_cnt++;
    end
    if (pass_done) pass_cnt++;
    @(negedge clk);
  endtask

  // Advance until the scrubber is reading the given address (READ cycle).
  task automatic wait_read(input logic [31:0] addr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (scrub_grant && !mem_we && mem_addr == addr) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0; scrub_en = 1'b0; core_req = 1'b0; core_we = 1'b0;
    core_addr = 32'h1234; core_wdata = 39'h0;
    step(); step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (scrub_grant !== 1'b0) begin bad++; $display("FAIL reset_grant: got %b want 0", scrub_grant); end
    total++; if (sb_count !== 16'd0 || db_count !== 16'd0) begin bad++; $display("FAIL reset_counts: got sb=%0d db=%0d want 0 0", sb_count, db_count); end
    total++; if (db_addr !== 32'd0 || db_err !== 1'b0 || pass_done !== 1'b0) begin bad++; $display("FAIL reset_flags: got addr=%h err=%b pd=%b want 0 0 0", db_addr, db_err, pass_done); end
    total++; if (mem_addr !== 32'h1234 || mem_we !== 1'b0) begin bad++; $display("FAIL reset_mux: got addr=%h we=%b want 00001234 0", mem_addr, mem_we); end
    rst_in = 1'b1; core_addr = 32'h0;
    for (int i = 0; i < 10; i++) step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL disabled_hold: got busy=%b want 0", busy); end
    $display("[tb] test_reset done");
  endtask

  task automatic test_clean_pass();
    int n;
    bit ok;
    scrub_en = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(); n++;
      if (scrub_grant) break;
    end
    total++; if (n !== 4 || mem_addr !== 32'h0) begin bad++; $display("FAIL first_latency: got %0d cycles addr=%h want 4 0", n, mem_addr); end
    for (int k = 1; k < 4; k++) begin
      wait_read(32'(k * 4), ok);
      total++; if (!ok) begin bad++; $display("FAIL clean_visit: got no read of word %0d want read", k); end
    end
    step();
    total++; if (pass_done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL pass_next: got pd=%b busy=%b want 0 1", pass_done, busy); end
    step();
    total++; if (pass_done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL pass_pulse: got pd=%b busy=%b want 1 0", pass_done, busy); end
    step();
    total++; if (pass_done !== 1'b0) begin bad++; $display("FAIL pass_width: got pd=%b want 0", pass_done); end
    total++; if (pass_cnt !== 1 || we_cnt !== 0 || sb_count !== 16'd0) begin bad++; $display("FAIL clean_summary: got passes=%0d writes=%0d sb=%0d want 1 0 0", pass_cnt, we_cnt, sb_count); end
    $display("[tb] test_clean_pass done");
  endtask

  task automatic test_single_bit();
    logic [38:0] expv;
    int w0;
    bit ok;
    expv = gold_arr[2];
    mem_arr[2] = mem_arr[2] ^ 39'h20;
    w0 = we_cnt;
    wait_read(32'h8, ok);
    total++; if (!ok || sb_count !== 16'd0) begin bad++; $display("FAIL sb_read: got ok=%b sb=%0d want 1 0", ok, sb_count); end
    step();
    total++; if (sb_count !== 16'd1) begin bad++; $display("FAIL sb_count: got %0d want 1", sb_count); end
    total++; if (mem_we !== 1'b1 || mem_addr !== 32'h8 || mem_wdata !== expv) begin bad++; $display("FAIL sb_wb: got we=%b addr=%h data=%h want 1 00000008 %h", mem_we, mem_addr, mem_wdata, expv); end
    step();
    total++; if (mem_arr[2] !== expv || mem_we !== 1'b0) begin bad++; $display("FAIL sb_fixed: got mem=%h we=%b want %h 0", mem_arr[2], mem_we, expv); end
    wait_read(32'h8, ok);
    step();
    total++; if (!ok || sb_count !== 16'd1 || mem_we !== 1'b0 || we_cnt - w0 !== 1) begin bad++; $display("FAIL sb_second_pass: got ok=%b sb=%0d we=%b writes=%0d want 1 1 0 1", ok, sb_count, mem_we, we_cnt - w0); end
    $display("[tb] test_single_bit done");
  endtask

  task automatic test_double_bit();
    int w0;
    bit ok;
    mem_arr[1] = mem_arr[1] ^ 39'h81;
    wait_read(32'h4, ok);
    w0 = we_cnt;
    total++; if (!ok || db_count !== 16'd0) begin bad++; $display("FAIL db_read: got ok=%b db=%0d want 1 0", ok, db_count); end
    step();
    total++; if (db_err !== 1'b1 || db_count !== 16'd1 || db_addr !== 32'h4) begin bad++; $display("FAIL db_detect: got err=%b db=%0d addr=%h want 1 1 00000004", db_err, db_count, db_addr); end
    total++; if (mem_we !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL db_no_wb: got we=%b busy=%b want 0 1", mem_we, busy); end
    step();
    total++; if (db_err !== 1'b0) begin bad++; $display("FAIL db_pulse: got err=%b want 0", db_err); end
    wait_read(32'h4, ok);
    step();
    total++; if (!ok || db_count !== 16'd2 || db_err !== 1'b1) begin bad++; $display("FAIL db_again: got ok=%b db=%0d err=%b want 1 2 1", ok, db_count, db_err); end
    total++; if (sb_count !== 16'd1 || we_cnt !== w0) begin bad++; $display("FAIL db_side: got sb=%0d writes=%0d want 1 %0d", sb_count, we_cnt, w0); end
    mem_arr[1] = gold_arr[1];
    $display("[tb] test_double_bit done");
  endtask

  task automatic test_core_priority();
    logic [38:0] expv;
    logic [31:0] a;
    bit ok;
    expv = gold_arr[3];
    mem_arr[3] = mem_arr[3] ^ 39'h10_0000;
    wait_read(32'hC, ok);
    total++; if (!ok) begin bad++; $display("FAIL prio_read: got no read want read of word 3"); end
    for (int i = 0; i < 10; i++) begin
      a = 32'h100 + 32'(i * 4);
      core_req = 1'b1; core_addr = a;
      #1;
      total++; if (scrub_grant !== 1'b0 || mem_addr !== a || busy !== 1'b1 || sb_count !== 16'd1) begin bad++; $display("FAIL prio_hold%0d: got grant=%b addr=%h busy=%b sb=%0d want 0 %h 1 1", i, scrub_grant, mem_addr, busy, sb_count, a); end
      step();
    end
    core_req = 1'b0; core_addr = 32'h0;
    #1;
    total++; if (scrub_grant !== 1'b1 || mem_addr !== 32'hC || mem_we !== 1'b0) begin bad++; $display("FAIL prio_resume: got grant=%b addr=%h we=%b want 1 0000000c 0", scrub_grant, mem_addr, mem_we); end
    step();
    total++; if (sb_count !== 16'd2 || mem_we !== 1'b1 || mem_addr !== 32'hC) begin bad++; $display("FAIL prio_wb: got sb=%0d we=%b addr=%h want 2 1 0000000c", sb_count, mem_we, mem_addr); end
    step();
    total++; if (mem_arr[3] !== expv) begin bad++; $display("FAIL prio_fixed: got %h want %h", mem_arr[3], expv); end
    $display("[tb] test_core_priority done");
  endtask

  task automatic test_wb_drop();
    logic [38:0] newv;
    int w0;
    bit ok;
    newv = 39'h5A_A5C3_3C0F;
    mem_arr[3] = mem_arr[3] ^ 39'h40_0000_0000;
    wait_read(32'hC, ok);
    step();
    total++; if (!ok || mem_we !== 1'b1 || scrub_grant !== 1'b1) begin bad++; $display("FAIL drop_enter_wb: got ok=%b we=%b grant=%b want 1 1 1", ok, mem_we, scrub_grant); end
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'hC; core_wdata = newv;
    #1;
    w0 = we_cnt;
    total++; if (scrub_grant !== 1'b0 || mem_we !== 1'b1 || mem_wdata !== newv) begin bad++; $display("FAIL drop_core_mux: got grant=%b we=%b data=%h want 0 1 %h", scrub_grant, mem_we, mem_wdata, newv); end
    step();
    core_req = 1'b0; core_we = 1'b0; core_addr = 32'h0;
    #1;
    total++; if (busy !== 1'b1 || scrub_grant !== 1'b0 || mem_arr[3] !== newv) begin bad++; $display("FAIL drop_next: got busy=%b grant=%b mem=%h want 1 0 %h", busy, scrub_grant, mem_arr[3], newv); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_idle: got busy=%b want 0", busy); end
    step(); step(); step();
    total++; if (mem_arr[3] !== newv || we_cnt - w0 !== 1) begin bad++; $display("FAIL drop_kept: got mem=%h writes=%0d want %h 1", mem_arr[3], we_cnt - w0, newv); end
    $display("[tb] test_wb_drop done");
  endtask

  task automatic test_reset_in_wb();
    logic [38:0] bad_word;
    logic [38:0] expv;
    int n;
    bit ok;
    expv = gold_arr[0];
    mem_arr[0] = mem_arr[0] ^ 39'h8;
    bad_word = mem_arr[0];
    wait_read(32'h0, ok);
    step();
    total++; if (!ok || mem_we !== 1'b1) begin bad++; $display("FAIL rstwb_enter: got ok=%b we=%b want 1 1", ok, mem_we); end
    rst_in = 1'b0;
    #1;
    total++; if (mem_we !== 1'b0 || scrub_grant !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstwb_outputs: got we=%b grant=%b busy=%b want 0 0 0", mem_we, scrub_grant, busy); end
    total++; if (sb_count !== 16'd0 || db_count !== 16'd0 || db_addr !== 32'd0) begin bad++; $display("FAIL rstwb_regs: got sb=%0d db=%0d addr=%h want 0 0 0", sb_count, db_count, db_addr); end
    step(); step();
    total++; if (mem_arr[0] !== bad_word) begin bad++; $display("FAIL rstwb_nowrite: got %h want %h", mem_arr[0], bad_word); end
    rst_in = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(); n++;
      if (scrub_grant) break;
    end
    total++; if (n !== 4 || mem_addr !== 32'h0) begin bad++; $display("FAIL rstwb_restart: got %0d cycles addr=%h want 4 0", n, mem_addr); end
    step();
    total++; if (sb_count !== 16'd1 || mem_we !== 1'b1) begin bad++; $display("FAIL rstwb_rescrub: got sb=%0d we=%b want 1 1", sb_count, mem_we); end
    step();
    total++; if (mem_arr[0] !== expv) begin bad++; $display("FAIL rstwb_fixed: got %h want %h", mem_arr[0], expv); end
    $display("[tb] test_reset_in_wb done");
  endtask

  initial begin
    gold_arr[0] = 39'h0A_BCDE_F012; gold_arr[1] = 39'h13_5724_6801;
    gold_arr[2] = 39'h7F_0F0F_1234; gold_arr[3] = 39'h22_DEAD_BEEF;
    for (int i = 0; i < 4; i++) mem_arr[i] = gold_arr[i];
    rst_in = 1'b0; scrub_en = 1'b0; core_req = 1'b0; core_we = 1'b0;
    core_addr = 32'h0; core_wdata = 39'h0;
    @(negedge clk);
    test_reset();
    test_clean_pass();
    test_single_bit();
    test_double_bit();
    test_core_priority();
    test_wb_drop();
    test_reset_in_wb();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
